// File: rtl/bit_stat_sequencer.sv
// Bounded up/down counter with a one-bit-per-cycle statistics scan
// (ones, non-leading zeros, significant length) run after every change.
module bit_stat_sequencer #(
  parameter int WIDTH   = 16,
  parameter int MAX_VAL = 9999,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic             cmd_ack,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             stat_valid,
  output logic [CNT_W-1:0] ones,
  output logic [CNT_W-1:0] zeros,
  output logic [CNT_W-1:0] bits
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] o_acc, o_acc_nxt;
  logic [CNT_W-1:0] z_acc, z_acc_nxt;
  logic [CNT_W-1:0] z_run, z_run_nxt;
  logic [WIDTH-1:0] value_nxt;
  logic [CNT_W-1:0] ones_nxt, zeros_nxt, bits_nxt;
  logic             busy_nxt, done_nxt, ack_nxt, valid_nxt;
  logic             accept;

  // Next-state, arithmetic and scan-step logic
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    o_acc_nxt = o_acc;
    z_acc_nxt = z_acc;
    z_run_nxt = z_run;
    value_nxt = value;
    ones_nxt  = ones;
    zeros_nxt = zeros;
    bits_nxt  = bits;
    busy_nxt  = busy;
    valid_nxt = stat_valid;
    done_nxt  = 1'b0;
    ack_nxt   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        // load wins outright; inc and dec together cancel out
        if (load) begin
          accept    = 1'b1;
          value_nxt = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (inc && !dec) begin
          accept    = 1'b1;
          value_nxt = (value == MAX_V) ? {WIDTH{1'b0}} : value + WIDTH'(1);
        end else if (dec && !inc) begin
          accept    = 1'b1;
          value_nxt = (value == {WIDTH{1'b0}}) ? MAX_V : value - WIDTH'(1);
        end else begin
          accept    = 1'b0;
        end
        if (accept) begin
          state_nxt = SCAN;
          ack_nxt   = 1'b1;
          busy_nxt  = 1'b1;
          valid_nxt = 1'b0;
          idx_nxt   = {IDX_W{1'b0}};
          o_acc_nxt = {CNT_W{1'b0}};
          z_acc_nxt = {CNT_W{1'b0}};
          z_run_nxt = {CNT_W{1'b0}};
        end else begin
          state_nxt = IDLE;
        end
      end
      SCAN: begin
        // Zeros are only committed once a higher 1 proves they are not leading
        if (value[idx]) begin
          o_acc_nxt = o_acc + CNT_W'(1);
          z_acc_nxt = z_acc + z_run;
          z_run_nxt = {CNT_W{1'b0}};
        end else begin
          z_run_nxt = z_run + CNT_W'(1);
        end
        idx_nxt = idx + IDX_W'(1);
        if (idx == LAST_IDX) begin
          state_nxt = IDLE;
          idx_nxt   = {IDX_W{1'b0}};
          ones_nxt  = o_acc_nxt;
          zeros_nxt = z_acc_nxt;
          bits_nxt  = o_acc_nxt + z_acc_nxt;
          busy_nxt  = 1'b0;
          valid_nxt = 1'b1;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = SCAN;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= {IDX_W{1'b0}};
      o_acc      <= {CNT_W{1'b0}};
      z_acc      <= {CNT_W{1'b0}};
      z_run      <= {CNT_W{1'b0}};
      value      <= {WIDTH{1'b0}};
      ones       <= {CNT_W{1'b0}};
      zeros      <= {CNT_W{1'b0}};
      bits       <= {CNT_W{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      cmd_ack    <= 1'b0;
      stat_valid <= 1'b1;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      o_acc      <= o_acc_nxt;
      z_acc      <= z_acc_nxt;
      z_run      <= z_run_nxt;
      value      <= value_nxt;
      ones       <= ones_nxt;
      zeros      <= zeros_nxt;
      bits       <= bits_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      cmd_ack    <= ack_nxt;
      stat_valid <= valid_nxt;
    end
  end

endmodule

// File: doc/bit_stat_sequencer.md
Name: bit_stat_sequencer

Overview:
Owns a bounded up/down counter value (0..MAX_VAL, four-digit range by default) and sequences a serial bit-statistics scan of it after every change. The scan reports three counts: the number of ones, the number of zeros excluding leading zeros, and the significant bit length. It sits between the increment/decrement/load command inputs and the display/statistics path, and replaces a combinational bit-counting loop with a one-bit-per-cycle engine guarded by a busy/done handshake.

Parameters:
WIDTH, 16, bit width of the value and load_val.
MAX_VAL, 9999, upper bound of the value; the increment and decrement wrap-around point.
CNT_W, 5, width of the ones, zeros and bits outputs; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
load  input  1  load command; takes load_val.
load_val  input  WIDTH  value to load; values above MAX_VAL are clamped to MAX_VAL.
inc  input  1  increment command.
dec  input  1  decrement command.
cmd_ack  output  1  one-cycle pulse: a command was accepted on the previous edge.
value  output  WIDTH  current counter value (registered).
busy  output  1  high while a scan is in progress.
done  output  1  one-cycle pulse: the scan has completed and the stats are updated.
stat_valid  output  1  high when ones, zeros and bits describe the current value.
ones  output  CNT_W  count of 1 bits in value.
zeros  output  CNT_W  count of 0 bits below the most significant 1 (leading zeros excluded).
bits  output  CNT_W  ones + zeros; equals 0 when value is 0.

Behaviour:
- Reset (async, rst_n=0), applies immediately including mid-scan: value=0, ones=0, zeros=0, bits=0, stat_valid=1, busy=0, done=0, cmd_ack=0, state=IDLE. Any in-flight scan is discarded.
- States:
  - IDLE: commands accepted here.
  - SCAN: 16 cycles, bit index 0..WIDTH-1, LSB first.
  - No separate DONE state; done is a registered pulse on the SCAN->IDLE edge.
- Command acceptance happens only in IDLE, sampled on the rising edge.
  - Priority: load > inc > dec.
  - inc and dec both high with load low: ignored, no ack, no scan.
  - Commands in SCAN are ignored (no queueing, no ack); the requester must hold or retry.
- Arithmetic on accept (edge E0):
  - load: value = min(load_val, MAX_VAL).
  - inc: value = (value==MAX_VAL) ? 0 : value+1.
  - dec: value = (value==0) ? MAX_VAL : value-1.
  - A load of the same value still triggers a scan.
- At E0:
  - cmd_ack=1 for one cycle.
  - busy=1, stat_valid=0.
  - Working registers cleared: o_acc=0, z_acc=0, z_run=0, idx=0.
  - ones/zeros/bits hold their previous results throughout the scan.
- SCAN, edge Ek (k=1..WIDTH), processes bit value[k-1]:
  - If the bit is 1: o_acc+1, z_acc+z_run, z_run=0.
  - Else: z_run+1.
- At edge E_WIDTH (16 edges after E0):
  - ones=o_acc', zeros=z_acc', bits=o_acc'+z_acc', using the final-bit updates.
  - busy=0, stat_valid=1, done=1 for one cycle, state=IDLE.
- Throughput: a new command is accepted at the earliest on the edge after done goes high, i.e. busy must be observed low. Minimum command period is WIDTH+1 cycles.
- All arithmetic is unsigned. No CNT_W overflow is possible: the maximum count is WIDTH=16 < 32.
- value is stable for the whole scan; the scan reads the registered value, not load_val.

Test Plan:
- Reset then idle → value=0, ones=0, zeros=0, bits=0, stat_valid=1, busy=0; no done pulse.
- load=1, load_val=0x00A5 → cmd_ack next cycle, busy for 16 cycles, done 16 edges after accept; ones=4, zeros=4, bits=8, value=165.
- load 9999 (0x270F), then inc → first scan gives ones=8, zeros=6, bits=14; after inc, value=0 with ones=0, zeros=0, bits=0 (wrap). dec from 0 → value=9999, ones=8, zeros=6, bits=14.
- load_val=0xFFFF → value clamped to 9999; load 4096 → ones=1, zeros=12, bits=13.
- inc asserted during busy, and inc+dec together in IDLE → no cmd_ack, value unchanged, no scan; load+inc together → load wins.
- rst_n pulsed low at scan cycle 7 after loading 0x00A5 → outputs return to reset values immediately; no done pulse; next command behaves normally.
